// File: rtl/jtframe_osd_seq.sv
// jtframe_osd_seq
// Sequencer and arbiter for the OSD byte-serial command port. It shares the
// io_osd/io_strobe/io_din bus between requester 0 (menu/framebuffer writer)
// and requester 1 (info-box writer). Each frame is one command byte followed
// by len 16-bit payload words. The words are read through a shared read port
// with 1-cycle latency.
//
// Parameters: STB_W (1..15) strobe high/low cycles, SETUP (>=1) io_osd lead
// and trail cycles, GAP (>=1) minimum io_osd low cycles between frames.
// Optional feature macro: JTFRAME_OSDSEQ_RR_EN selects round-robin
// arbitration. When it is undefined, requester 1 has fixed priority.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[1:0]          request level per requester
//   cmd0/cmd1, len0/len1   command byte and payload word count (0..4096)
//   done[1:0]         one-cycle completion pulse per requester
//   busy              FSM not idle
//   rd_addr, rd_sel   payload word index and granted requester
//   rd_data           payload word, valid one cycle after rd_addr
//   io_osd, io_strobe, io_din   OSD command bus
//   osd_on            last enable state sent to the OSD
module jtframe_osd_seq #(
  parameter int unsigned STB_W = 2,
  parameter int unsigned SETUP = 2,
  parameter int unsigned GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [12:0] len0,
  input  logic [12:0] len1,
  output logic [1:0]  done,
  output logic        busy,
  output logic [12:0] rd_addr,
  output logic        rd_sel,
  input  logic [15:0] rd_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        osd_on
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_STBH  = 3'd3;
  localparam logic [2:0] ST_STBL  = 3'd4;
  localparam logic [2:0] ST_FETCH = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;
  localparam logic [2:0] ST_GAP   = 3'd7;

  localparam logic [15:0] C_SETUP = 16'(SETUP - 1);
  localparam logic [15:0] C_STB   = 16'(STB_W - 1);
  localparam logic [15:0] C_GAP   = 16'(GAP - 1);

  logic [2:0]  r_st;
  logic [15:0] r_cnt;
  logic        r_g;
  logic [7:0]  r_cmd;
  logic [12:0] r_len;
  logic [12:0] r_wc;
  logic        r_osd;
  logic        r_stb;
  logic [15:0] r_din;
  logic [1:0]  r_done;
  logic        r_on;
  logic        w_g;

`ifdef JTFRAME_OSDSEQ_RR_EN
  // r_ptr holds the last served requester; on contention the other one wins
  logic r_ptr;

  always_comb w_g = (req == 2'b11) ? ~r_ptr : req[1];

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= 1'b0;
    else if (r_st == ST_IDLE && |req)
      r_ptr <= w_g;
  end
`else
  always_comb w_g = req[1];
`endif

  // io_din is loaded on entry to LOAD, so it is stable for a full cycle
  // before the strobe rises. rd_addr follows wc continuously. wc only moves
  // when leaving FETCH, so rd_data for the current word is already valid
  // during FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_g    <= 1'b0;
      r_cmd  <= '0;
      r_len  <= '0;
      r_wc   <= '0;
      r_osd  <= 1'b0;
      r_stb  <= 1'b0;
      r_din  <= '0;
      r_done <= '0;
      r_on   <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_st)
        ST_IDLE: begin
          if (|req) begin
            r_g   <= w_g;
            r_cmd <= w_g ? cmd1 : cmd0;
            r_len <= w_g ? len1 : len0;
            r_wc  <= '0;
            r_cnt <= '0;
            r_osd <= 1'b1;
            r_st  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == C_SETUP) begin
            r_cnt <= '0;
            r_din <= {8'h00, r_cmd};
            r_st  <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_LOAD: begin
          r_cnt <= '0;
          r_stb <= 1'b1;
          r_st  <= ST_STBH;
        end
        ST_STBH: begin
          if (r_cnt == C_STB) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
            r_st  <= ST_STBL;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STBL: begin
          if (r_cnt == C_STB) begin
            r_cnt <= '0;
            r_st  <= (r_wc < r_len) ? ST_FETCH : ST_HOLD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_FETCH: begin
          r_din <= rd_data;
          r_wc  <= r_wc + 13'd1;
          r_st  <= ST_LOAD;
        end
        ST_HOLD: begin
          if (r_cnt == C_SETUP) begin
            r_cnt  <= '0;
            r_osd  <= 1'b0;
            r_done <= r_g ? 2'b10 : 2'b01;
            if (r_cmd[7:4] == 4'h4)
              r_on <= r_cmd[0];
            r_st   <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_GAP: begin
          if (r_cnt == C_GAP) begin
            r_cnt <= '0;
            r_st  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign busy      = (r_st != ST_IDLE);
  assign rd_addr   = r_wc;
  assign rd_sel    = r_g;
  assign io_osd    = r_osd;
  assign io_strobe = r_stb;
  assign io_din    = r_din;
  assign osd_on    = r_on;

endmodule

// File: tb/tb_jtframe_osd_seq.sv
// Directed self-checking bench for jtframe_osd_seq. Instance 0 uses STB_W=2,
// instance 1 uses STB_W=1 and instance 2 uses STB_W=3. All instances use
// SETUP=2 and GAP=2. The bench models the read port as a synchronous RAM.
module tb_jtframe_osd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_v[3];
  logic [7:0]  cmd0_v[3], cmd1_v[3];
  logic [12:0] len0_v[3], len1_v[3];
  logic [1:0]  done_v[3];
  logic        busy_v[3];
  logic [12:0] rd_addr_v[3];
  logic        rd_sel_v[3];
  logic [15:0] rd_data_v[3];
  logic        osd_v[3], stb_v[3], on_v[3];
  logic [15:0] din_v[3];

  logic [15:0] mem0[16], mem1[16];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    jtframe_osd_seq #(
      .STB_W((k == 0) ? 2 : ((k == 1) ? 1 : 3)),
      .SETUP(2),
      .GAP  (2)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req_v[k]),
      .cmd0     (cmd0_v[k]),
      .cmd1     (cmd1_v[k]),
      .len0     (len0_v[k]),
      .len1     (len1_v[k]),
      .done     (done_v[k]),
      .busy     (busy_v[k]),
      .rd_addr  (rd_addr_v[k]),
      .rd_sel   (rd_sel_v[k]),
      .rd_data  (rd_data_v[k]),
      .io_osd   (osd_v[k]),
      .io_strobe(stb_v[k]),
      .io_din   (din_v[k]),
      .osd_on   (on_v[k])
    );
  end

  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      rd_data_v[k] <= rd_sel_v[k] ? mem1[rd_addr_v[k][3:0]] : mem0[rd_addr_v[k][3:0]];

  int checks = 0;
  int failures = 0;

  int          hi, nstb, viol, gapc;
  logic [1:0]  dn;
  logic        dn_osd, dn_on, tmo;
  logic [15:0] stbd[8];
  logic        prev_stb;
  logic [15:0] prev_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows one frame of instance i up to and including its done cycle.
  task run_frame(input int i, input int max_cyc);
    hi = 0; nstb = 0; viol = 0; dn = '0; dn_osd = 1'bx; dn_on = 1'bx; tmo = 1'b1;
    prev_stb = stb_v[i];
    prev_din = din_v[i];
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (osd_v[i]) hi++;
      if (stb_v[i] && !prev_stb) begin
        if (din_v[i] !== prev_din) viol++;
        if (nstb < 8) stbd[nstb] = din_v[i];
        nstb++;
      end
      if (stb_v[i] && prev_stb && din_v[i] !== prev_din) viol++;
      prev_stb = stb_v[i];
      prev_din = din_v[i];
      if (done_v[i] != 2'b00) begin
        dn = done_v[i]; dn_osd = osd_v[i]; dn_on = on_v[i]; tmo = 1'b0;
        break;
      end
    end
  endtask

  // Counts io_osd-low cycles while busy, starting from the done cycle.
  task wait_idle(input int i);
    gapc = 1;
    tmo = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy_v[i]) begin tmo = 1'b0; break; end
      if (!osd_v[i]) gapc++;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_v[k] = '0; cmd0_v[k] = '0; cmd1_v[k] = '0; len0_v[k] = '0; len1_v[k] = '0;
    end
    for (int a = 0; a < 16; a++) begin mem0[a] = '0; mem1[a] = '0; end
    mem1[0] = 16'h0011; mem1[1] = 16'h0022; mem1[2] = 16'h0033;
    mem0[0] = 16'h00A0; mem0[1] = 16'h00A1; mem0[2] = 16'h00A2;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_osd",    32'(osd_v[0]), 0);
    check("rst_strobe", 32'(stb_v[0]), 0);
    check("rst_din",    32'(din_v[0]), 0);
    check("rst_done",   32'(done_v[0]), 0);
    check("rst_busy",   32'(busy_v[0]), 0);
    check("rst_rdaddr", 32'(rd_addr_v[0]), 0);
    check("rst_rdsel",  32'(rd_sel_v[0]), 0);
    check("rst_osdon",  32'(on_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Command only: cmd0=0x41, len0=0
    cmd0_v[0] = 8'h41; len0_v[0] = 13'd0; req_v[0] = 2'b01;
    run_frame(0, 100);
    req_v[0] = 2'b00;
    check("c1_timeout", 32'(tmo), 0);
    check("c1_osd_hi",  32'(hi), 9);
    check("c1_nstb",    32'(nstb), 1);
    check("c1_din0",    32'(stbd[0]), 32'h0041);
    check("c1_done",    32'(dn), 32'h1);
    check("c1_osd_fall", 32'(dn_osd), 0);
    check("c1_osd_on",  32'(dn_on), 1);
    check("c1_integ",   32'(viol), 0);
    wait_idle(0);
    check("c1_gap",     32'(gapc), 2);

    // Payload burst: cmd1=0x20, len1=3
    cmd1_v[0] = 8'h20; len1_v[0] = 13'd3; req_v[0] = 2'b10;
    run_frame(0, 200);
    req_v[0] = 2'b00;
    check("p_timeout", 32'(tmo), 0);
    check("p_osd_hi",  32'(hi), 27);
    check("p_nstb",    32'(nstb), 4);
    check("p_din0",    32'(stbd[0]), 32'h0020);
    check("p_din1",    32'(stbd[1]), 32'h0011);
    check("p_din2",    32'(stbd[2]), 32'h0022);
    check("p_din3",    32'(stbd[3]), 32'h0033);
    check("p_done",    32'(dn), 32'h2);
    check("p_osd_on",  32'(dn_on), 1);
    check("p_integ",   32'(viol), 0);
    wait_idle(0);

    // Disable: cmd0=0x40
    cmd0_v[0] = 8'h40; len0_v[0] = 13'd0; req_v[0] = 2'b01;
    run_frame(0, 100);
    req_v[0] = 2'b00;
    check("d_done",    32'(dn), 32'h1);
    check("d_osd_on",  32'(dn_on), 0);
    wait_idle(0);
    check("d_idle_to", 32'(tmo), 0);
    check("d_gap",     32'(gapc), 2);

    // Contention with both requests held and len=0
    cmd0_v[0] = 8'h10; cmd1_v[0] = 8'h12; len0_v[0] = 13'd0; len1_v[0] = 13'd0;
    req_v[0] = 2'b11;
    run_frame(0, 100);
    check("ct1_done",  32'(dn), 32'h2);
    check("ct1_din",   32'(stbd[0]), 32'h0012);
    run_frame(0, 100);
`ifdef JTFRAME_OSDSEQ_RR_EN
    check("ct2_done",  32'(dn), 32'h1);
    run_frame(0, 100);
    req_v[0] = 2'b00;
    check("ct3_done",  32'(dn), 32'h2);
`else
    check("ct2_done",  32'(dn), 32'h2);
    req_v[0] = 2'b01;
    run_frame(0, 100);
    req_v[0] = 2'b00;
    check("ct3_done",  32'(dn), 32'h1);
    check("ct3_din",   32'(stbd[0]), 32'h0010);
`endif
    check("ct3_osd_hi", 32'(hi), 9);
    wait_idle(0);

    // Strobe integrity with STB_W=1 and STB_W=3
    cmd1_v[1] = 8'h22; len1_v[1] = 13'd3; req_v[1] = 2'b10;
    run_frame(1, 200);
    req_v[1] = 2'b00;
    check("s1_osd_hi", 32'(hi), 19);
    check("s1_nstb",   32'(nstb), 4);
    check("s1_din3",   32'(stbd[3]), 32'h0033);
    check("s1_integ",  32'(viol), 0);
    wait_idle(1);
    cmd1_v[2] = 8'h22; len1_v[2] = 13'd3; req_v[2] = 2'b10;
    run_frame(2, 200);
    req_v[2] = 2'b00;
    check("s3_osd_hi", 32'(hi), 35);
    check("s3_nstb",   32'(nstb), 4);
    check("s3_din1",   32'(stbd[1]), 32'h0011);
    check("s3_integ",  32'(viol), 0);
    wait_idle(2);

    // Reset during the second strobe-high phase
    cmd0_v[0] = 8'h31; len0_v[0] = 13'd3; req_v[0] = 2'b01;
    nstb = 0;
    tmo = 1'b1;
    prev_stb = stb_v[0];
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stb_v[0] && !prev_stb) nstb++;
      prev_stb = stb_v[0];
      if (nstb == 2) begin tmo = 1'b0; break; end
    end
    check("r_reach_stb2", 32'(tmo), 0);
    rst = 1'b1;
    req_v[0] = 2'b00;
    @(negedge clk);
    check("r_osd",    32'(osd_v[0]), 0);
    check("r_strobe", 32'(stb_v[0]), 0);
    check("r_busy",   32'(busy_v[0]), 0);
    check("r_done",   32'(done_v[0]), 0);
    check("r_rdaddr", 32'(rd_addr_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    len0_v[0] = 13'd1; req_v[0] = 2'b01;
    run_frame(0, 100);
    req_v[0] = 2'b00;
    check("r2_osd_hi", 32'(hi), 15);
    check("r2_nstb",   32'(nstb), 2);
    check("r2_din1",   32'(stbd[1]), 32'h00A0);
    check("r2_done",   32'(dn), 32'h1);
    wait_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
